// File: rtl/hazard_unit_if.sv
// Hazard-control bundle between the pipeline (master) and the hazard unit (slave).
// Carries ID/EX hazard inputs and the PC / IF/ID / ID/EX enable and bubble controls.
interface hazard_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              ex_valid;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              pipe_freeze;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, ex_valid, ex_mem_read,
           ex_rd, ex_branch_taken, pipe_freeze,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, stall, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, ex_valid, ex_mem_read,
           ex_rd, ex_branch_taken, pipe_freeze,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, stall, stall_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use hazard controller with a per-register scoreboard of loads still in MEM,
// taken-branch flush, global freeze and a saturating stall-cycle counter.
module hazard_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hz
);
  localparam int unsigned NREGS = 2 ** REG_AW;
  localparam int unsigned PW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [PW-1:0]    r_pend [NREGS];
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_ex_load;
  logic w_hit_rs;
  logic w_hit_rt;
  logic w_stall;

  // A source hazards if the load in EX writes it or an older load is still in MEM.
  always_comb begin
    w_ex_load = hz.ex_valid & hz.ex_mem_read;
    w_hit_rs  = (hz.id_rs != '0) &&
                ((w_ex_load && (hz.ex_rd == hz.id_rs)) || (r_pend[hz.id_rs] != '0));
    w_hit_rt  = (hz.id_rt != '0) &&
                ((w_ex_load && (hz.ex_rd == hz.id_rt)) || (r_pend[hz.id_rt] != '0));
    w_stall   = ~hz.pipe_freeze & ~hz.ex_branch_taken &
                ((hz.id_rs_used & w_hit_rs) | (hz.id_rt_used & w_hit_rt));
  end

  // Priority: freeze, then branch flush, then load-use stall.
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    hz.stall        = 1'b0;
    if (hz.pipe_freeze) begin
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
    end else if (hz.ex_branch_taken) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_bubble = 1'b1;
    end else if (w_stall) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_bubble = 1'b1;
      hz.stall        = 1'b1;
    end
  end

  // Scoreboard: count down pending loads; a new load in EX restarts its entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) r_pend[i] <= '0;
    end else if (!hz.pipe_freeze) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (r_pend[i] != '0) r_pend[i] <= r_pend[i] - PW'(1);
      end
      if (w_ex_load && (hz.ex_rd != '0)) r_pend[hz.ex_rd] <= PW'(MEM_LAT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: three instances (MEM_LAT=1, MEM_LAT=3, CNT_W=2),
// directed per-cycle vectors push expected outputs, a negedge monitor compares them.
module tb_hazard_unit;
  localparam logic [4:0] NRM = 5'b11000; // pc_write, if_id_write, flush, bubble, stall
  localparam logic [4:0] STL = 5'b00011;
  localparam logic [4:0] BRN = 5'b11110;
  localparam logic [4:0] FRZ = 5'b00000;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic       exv;
    logic       exr;
    logic [4:0] exrd;
    logic       br;
    logic       frz;
  } stim_t;

  typedef struct {
    int          dut;
    logic [4:0]  o;
    logic [15:0] c;
    string       tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    sel = 0;
  stim_t stim = '0;
  stim_t s_a, s_b, s_c;
  exp_t  exp_q[$];
  exp_t  e;
  logic [4:0]  act_o;
  logic [15:0] act_c;
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_AW(5), .CNT_W(16)) ifa ();
  hazard_unit_if #(.REG_AW(5), .CNT_W(16)) ifb ();
  hazard_unit_if #(.REG_AW(5), .CNT_W(2))  ifc ();

  hazard_unit #(.REG_AW(5), .MEM_LAT(1), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .hz(ifa));
  hazard_unit #(.REG_AW(5), .MEM_LAT(3), .CNT_W(16)) u_b (.clk(clk), .rst(rst), .hz(ifb));
  hazard_unit #(.REG_AW(5), .MEM_LAT(3), .CNT_W(2))  u_c (.clk(clk), .rst(rst), .hz(ifc));

  // Only the selected instance sees the vector; the others idle with zero inputs.
  always_comb begin
    s_a = (sel == 0) ? stim : '0;
    s_b = (sel == 1) ? stim : '0;
    s_c = (sel == 2) ? stim : '0;
  end

  assign {ifa.id_rs, ifa.id_rt, ifa.id_rs_used, ifa.id_rt_used, ifa.ex_valid,
          ifa.ex_mem_read, ifa.ex_rd, ifa.ex_branch_taken, ifa.pipe_freeze} = s_a;
  assign {ifb.id_rs, ifb.id_rt, ifb.id_rs_used, ifb.id_rt_used, ifb.ex_valid,
          ifb.ex_mem_read, ifb.ex_rd, ifb.ex_branch_taken, ifb.pipe_freeze} = s_b;
  assign {ifc.id_rs, ifc.id_rt, ifc.id_rs_used, ifc.id_rt_used, ifc.ex_valid,
          ifc.ex_mem_read, ifc.ex_rd, ifc.ex_branch_taken, ifc.pipe_freeze} = s_c;

  task automatic step(input int d, input logic r,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic rsu, input logic rtu, input logic exv, input logic exr,
                      input logic [4:0] exrd, input logic br, input logic frz,
                      input logic [4:0] o, input logic [15:0] c, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst  = r;
    sel  = d;
    stim = '{rs: rs, rt: rt, rsu: rsu, rtu: rtu, exv: exv, exr: exr,
             exrd: exrd, br: br, frz: frz};
    x.dut = d;
    x.o   = o;
    x.c   = c;
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.dut)
        0: begin
          act_o = {ifa.pc_write, ifa.if_id_write, ifa.if_id_flush, ifa.id_ex_bubble, ifa.stall};
          act_c = 16'(ifa.stall_cnt);
        end
        1: begin
          act_o = {ifb.pc_write, ifb.if_id_write, ifb.if_id_flush, ifb.id_ex_bubble, ifb.stall};
          act_c = 16'(ifb.stall_cnt);
        end
        default: begin
          act_o = {ifc.pc_write, ifc.if_id_write, ifc.if_id_flush, ifc.id_ex_bubble, ifc.stall};
          act_c = 16'(ifc.stall_cnt);
        end
      endcase
      total++;
      if ((act_o !== e.o) || (act_c !== e.c)) begin
        bad++;
        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 e.tag, act_o, act_c, e.o, e.c);
      end
    end
  end

  initial begin
    // MEM_LAT=1: classic single bubble, r0, branch priority, unused source.
    step(0,1, 0,0,0,0, 0,0,0, 0,0, NRM,0,"a_reset");
    step(0,0, 0,3,0,1, 1,1,3, 0,0, STL,0,"a_lu_stall");
    step(0,0, 0,3,0,1, 0,0,0, 0,0, NRM,1,"a_lu_release");
    step(0,0, 0,0,1,1, 1,1,0, 0,0, NRM,1,"a_r0_load");
    step(0,0, 0,4,0,1, 1,1,4, 1,0, BRN,1,"a_branch");
    step(0,0, 4,5,0,1, 1,1,4, 0,0, NRM,1,"a_unused_rs");
    // MEM_LAT=3: three-cycle stall, independent reader.
    step(1,0, 0,5,0,1, 1,1,5, 0,0, STL,0,"b_stall1");
    step(1,0, 0,5,0,1, 0,0,0, 0,0, STL,1,"b_stall2");
    step(1,0, 0,5,0,1, 0,0,0, 0,0, STL,2,"b_stall3");
    step(1,0, 0,5,0,1, 0,0,0, 0,0, NRM,3,"b_release");
    step(1,0, 6,0,1,0, 1,1,5, 0,0, NRM,3,"b_indep_ex");
    step(1,0, 6,0,1,0, 0,0,0, 0,0, NRM,3,"b_indep_pend");
    step(1,0, 0,0,0,0, 0,0,0, 0,0, NRM,3,"b_idle");
    // Freeze in the middle of the stall window.
    step(1,0, 0,5,0,1, 1,1,5, 0,0, STL,3,"b_fz_stall1");
    step(1,0, 0,5,0,1, 0,0,0, 0,1, FRZ,4,"b_fz_hold1");
    step(1,0, 0,5,0,1, 0,0,0, 0,1, FRZ,4,"b_fz_hold2");
    step(1,0, 0,5,0,1, 0,0,0, 0,0, STL,4,"b_fz_stall2");
    step(1,0, 0,5,0,1, 0,0,0, 0,0, STL,5,"b_fz_stall3");
    step(1,0, 0,5,0,1, 0,0,0, 0,0, NRM,6,"b_fz_release");
    // Back-to-back loads to r7 restart the pending count.
    step(1,0, 0,1,0,1, 1,1,7, 0,0, NRM,6,"b_ld7_first");
    step(1,0, 0,2,0,1, 1,1,7, 0,0, NRM,6,"b_ld7_second");
    step(1,0, 7,0,1,0, 0,0,0, 0,0, STL,6,"b_ld7_stall1");
    step(1,0, 7,0,1,0, 0,0,0, 0,0, STL,7,"b_ld7_stall2");
    step(1,0, 7,0,1,0, 0,0,0, 0,0, NRM,8,"b_ld7_release");
    // Branch keeps the load pending; reset mid-stall empties the scoreboard.
    step(1,0, 0,7,0,1, 1,1,7, 1,0, BRN,8,"b_br_load");
    step(1,0, 0,7,0,1, 0,0,0, 0,0, STL,8,"b_br_pending");
    step(1,1, 0,0,0,0, 0,0,0, 0,0, NRM,9,"b_rst_cycle");
    step(1,0, 0,7,0,1, 0,0,0, 0,0, NRM,0,"b_after_rst");
    // CNT_W=2: counter saturates at 3, reset clears it.
    step(2,0, 0,5,0,1, 1,1,5, 0,0, STL,0,"c_stall1");
    step(2,0, 0,5,0,1, 0,0,0, 0,0, STL,1,"c_stall2");
    step(2,0, 0,5,0,1, 0,0,0, 0,0, STL,2,"c_stall3");
    step(2,0, 0,5,0,1, 1,1,5, 0,0, STL,3,"c_stall4");
    step(2,0, 0,5,0,1, 0,0,0, 0,0, STL,3,"c_sat1");
    step(2,0, 0,5,0,1, 0,0,0, 0,0, STL,3,"c_sat2");
    step(2,0, 0,5,0,1, 0,0,0, 0,0, NRM,3,"c_sat_hold");
    step(2,1, 0,0,0,0, 0,0,0, 0,0, NRM,3,"c_rst_cycle");
    step(2,0, 0,5,0,1, 0,0,0, 0,0, NRM,0,"c_after_rst");
    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised load-use hazard controller for the 5-stage pipeline, sitting beside the ID stage and driving the PC, IF/ID and ID/EX control. It generalises single-cycle load-use detection to a data memory with configurable latency by keeping a per-register scoreboard of loads still in flight past EX. It also handles taken-branch flush, a global memory freeze and a saturating stall-cycle counter.

## Interface
Parameters:
- REG_AW, 5, register address width; NREGS = 2**REG_AW scoreboard entries
- MEM_LAT, 1, cycles a load spends in MEM before its data is forwardable (>=1); MEM_LAT=1 gives classic one-bubble load-use
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous and active-high
- id_rs  in  REG_AW  source register 1 of instruction in ID
- id_rt  in  REG_AW  source register 2 of instruction in ID
- id_rs_used  in  1  ID instruction actually reads id_rs
- id_rt_used  in  1  ID instruction actually reads id_rt
- ex_valid  in  1  ID/EX holds a real instruction (not bubble)
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_AW  load destination in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- pipe_freeze  in  1  data memory busy; whole pipeline holds
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  clear IF/ID to bubble
- id_ex_bubble  out  1  load a bubble into ID/EX instead of the ID instruction
- stall  out  1  load-use stall this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard: NREGS down-counters, width clog2(MEM_LAT) (min 1 bit); entry r "pending" when nonzero. Register 0 is never pending and never hazards.
- hit(r) = r!=0 and ((ex_valid & ex_mem_read & ex_rd==r) or pend[r]!=0).
- stall = ~pipe_freeze & ~ex_branch_taken & ((id_rs_used & hit(id_rs)) | (id_rt_used & hit(id_rt))).
- Output priority, combinational from inputs and scoreboard:
  - pipe_freeze=1: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, stall=0.
  - else ex_branch_taken=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
  - else stall=1: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1.
  - else: pc_write=1, if_id_write=1, flush=0, bubble=0.
- Scoreboard update, skipped entirely when pipe_freeze=1 (all entries hold):
  - every nonzero entry decrements by 1;
  - if ex_valid & ex_mem_read & ex_rd!=0: pend[ex_rd] <= MEM_LAT-1. This overrides the decrement for that entry, so a newer load to a still-pending register restarts its count.
  - a taken branch does not clear the scoreboard; the load in EX is older than the branch target.
- stall_cnt increments by 1 on each cycle with stall=1 and holds at 2**CNT_W-1.

## Timing
- Reset (rst high at clk edge): all scoreboard entries 0 and stall_cnt 0. During the reset cycle outputs follow the combinational rules with an empty scoreboard.
- Zero-latency decision: outputs change in the same cycle as inputs, with no registered output.
- A load in EX followed by a dependent instruction in ID gives exactly MEM_LAT stall cycles, excluding freeze cycles, which extend the stall window 1:1.
- A dependent instruction issued k cycles after the load's EX cycle stalls max(0, MEM_LAT-k) cycles.
- Reset asserted mid-stall clears pending entries. The next cycle has no stall unless a load is in EX.

## Test plan
- MEM_LAT=1, load r3 in EX, ID reads r3 via rt: 1 cycle with stall=1, pc_write=0, id_ex_bubble=1; next cycle all enables 1, stall_cnt=1.
- MEM_LAT=3, load r5, dependent in ID: stall=1 for exactly 3 consecutive cycles. An independent r6 reader in ID sees no stall.
- MEM_LAT=3, load r5, then pipe_freeze=1 for 2 cycles during the stall: outputs held for 2 cycles and the stall lasts 3 non-freeze cycles. Total 5 cycles before pc_write=1.
- Load r0 in EX with ID reading r0: no stall. Load r4 in EX plus ex_branch_taken=1 with ID reading r4: if_id_flush=1, bubble=1, stall=0, pc_write=1.
- MEM_LAT=3, load r7, then second load r7 one cycle later: pend[r7] reloads to 2. A reader of r7 stalls until 3 cycles after the second load.
- CNT_W=2: 5 stall cycles leave stall_cnt=3 (saturated). rst clears it to 0 and empties the scoreboard.
